// File: rtl/mult_mem_engine.sv
// Multiply / multiply-accumulate engine that streams results into an external
// memory, plus a back-pressured block reader that replays the last batch.
module mult_mem_engine #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 16,
  parameter int ADDR_W   = 6,
  parameter int SIGNED   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EN_mult,
  input  logic                mode,
  input  logic [ADDR_W:0]     batch_len,
  input  logic                mult_valid,
  input  logic [IN_WIDTH-1:0] mult_input0,
  input  logic [IN_WIDTH-1:0] mult_input1,
  output logic                RDY_mult,
  output logic                EN_writeMem,
  output logic [ADDR_W-1:0]   writeMem_addr,
  output logic [WIDTH-1:0]    writeMem_val,
  output logic                DONE_mult,
  input  logic                EN_blockRead,
  output logic                EN_readMem,
  output logic [ADDR_W-1:0]   readMem_addr,
  input  logic [WIDTH-1:0]    readMem_val,
  output logic                VALID_memVal,
  output logic [WIDTH-1:0]    memVal_data,
  input  logic                memVal_ready,
  output logic                DONE_read,
  output logic                busy
);

  localparam int LW = ADDR_W + 1;
  localparam int PW = 2 * IN_WIDTH;
  localparam logic [LW-1:0] DEPTH_L = LW'(1 << ADDR_W);

  typedef enum logic [1:0] {IDLE, MULT, READ} state_t;
  state_t state, nextState;

  logic [LW-1:0]     lenQ, accCnt, lastLen, rdCnt, xferCnt, effLen;
  logic              modeQ, wrEnQ, doneQ, rdPend;
  logic [ADDR_W-1:0] wrAddrQ;
  logic [WIDTH-1:0]  acc, accNext, prod, wrValQ;
  logic [PW-1:0]     opA, opB, prodFull;
  logic [WIDTH-1:0]  fifo [2];
  logic              wPtr, rPtr;
  logic [1:0]        occ;
  logic [2:0]        pendN;
  logic              rdyInt, accept, issue, pop, lastXfer;

  generate
    if (SIGNED != 0) begin : g_sext
      assign opA = {{IN_WIDTH{mult_input0[IN_WIDTH-1]}}, mult_input0};
      assign opB = {{IN_WIDTH{mult_input1[IN_WIDTH-1]}}, mult_input1};
    end else begin : g_zext
      assign opA = {{IN_WIDTH{1'b0}}, mult_input0};
      assign opB = {{IN_WIDTH{1'b0}}, mult_input1};
    end
  endgenerate

  assign prodFull = opA * opB;

  generate
    if (WIDTH > PW) begin : g_wide
      logic ext;
      assign ext  = (SIGNED != 0) ? prodFull[PW-1] : 1'b0;
      assign prod = {{(WIDTH-PW){ext}}, prodFull};
    end else begin : g_trunc
      assign prod = prodFull[WIDTH-1:0];
    end
  endgenerate

  // Lengths beyond DEPTH are clamped so counters never wrap.
  always_comb begin
    effLen = batch_len;
    if (batch_len == '0 || batch_len > DEPTH_L)
      effLen = DEPTH_L;
  end

  assign accNext  = acc + prod;
  assign rdyInt   = (state == MULT) && (accCnt < lenQ);
  assign accept   = rdyInt && mult_valid;
  assign pop      = (occ != 2'd0) && memVal_ready;
  // A same-cycle pop frees a slot, keeping full throughput without overflow.
  assign pendN    = 3'(occ) + 3'(rdPend) - 3'(pop);
  assign issue    = (state == READ) && (rdCnt < lastLen)
                    && (pendN < 3'd2);
  assign lastXfer = (state == READ) && pop
                    && (xferCnt == lastLen - LW'(1));

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (EN_mult)
          nextState = MULT;
        else if (EN_blockRead)
          nextState = READ;
      end
      MULT: if (doneQ) nextState = IDLE;
      READ: if (lastXfer) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      modeQ   <= 1'b0;
      lenQ    <= '0;
      accCnt  <= '0;
      acc     <= '0;
      wrEnQ   <= 1'b0;
      doneQ   <= 1'b0;
      wrAddrQ <= '0;
      wrValQ  <= '0;
      lastLen <= DEPTH_L;
      rdCnt   <= '0;
      xferCnt <= '0;
      rdPend  <= 1'b0;
      wPtr    <= 1'b0;
      rPtr    <= 1'b0;
      occ     <= 2'd0;
    end else begin
      state  <= nextState;
      wrEnQ  <= accept;
      doneQ  <= accept && (accCnt + LW'(1) == lenQ);
      rdPend <= issue;
      if (state == IDLE && EN_mult) begin
        modeQ  <= mode;
        lenQ   <= effLen;
        accCnt <= '0;
        acc    <= '0;
      end
      if (accept) begin
        accCnt  <= accCnt + LW'(1);
        acc     <= accNext;
        wrAddrQ <= accCnt[ADDR_W-1:0];
        wrValQ  <= modeQ ? accNext : prod;
      end
      if (doneQ)
        lastLen <= lenQ;
      if (state == IDLE && !EN_mult && EN_blockRead) begin
        rdCnt   <= '0;
        xferCnt <= '0;
      end
      if (issue)
        rdCnt <= rdCnt + LW'(1);
      if (rdPend) begin
        fifo[wPtr] <= readMem_val;
        wPtr       <= ~wPtr;
      end
      if (pop) begin
        rPtr    <= ~rPtr;
        xferCnt <= xferCnt + LW'(1);
      end
      occ <= occ + 2'(rdPend) - 2'(pop);
    end
  end

  assign busy          = rst && (state != IDLE);
  assign RDY_mult      = rst && rdyInt;
  assign EN_writeMem   = rst && wrEnQ;
  assign writeMem_addr = rst ? wrAddrQ : '0;
  assign writeMem_val  = rst ? wrValQ : '0;
  assign DONE_mult     = rst && doneQ;
  assign EN_readMem    = rst && issue;
  assign readMem_addr  = EN_readMem ? rdCnt[ADDR_W-1:0] : '0;
  assign VALID_memVal  = rst && (occ != 2'd0);
  assign memVal_data   = VALID_memVal ? fifo[rPtr] : '0;
  assign DONE_read     = rst && lastXfer;

endmodule

// File: tb/tb_mult_mem_engine.sv
// Directed bench for mult_mem_engine: memory model, write/read monitors,
// unsigned and signed instances driven by the same stimulus.
module tb_mult_mem_engine;

  localparam int W  = 32;
  localparam int IW = 16;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          EN_mult, mode, mult_valid, EN_blockRead, memVal_ready;
  logic [AW:0]   batch_len;
  logic [IW-1:0] mult_input0, mult_input1;
  logic          RDY_mult, EN_writeMem, DONE_mult, EN_readMem;
  logic          VALID_memVal, DONE_read, busy;
  logic [AW-1:0] writeMem_addr, readMem_addr;
  logic [W-1:0]  writeMem_val, readMem_val, memVal_data;

  logic          sRdy, sWe, sDone, sRe, sValid, sDoneRd, sBusy;
  logic [AW-1:0] sWa, sRa;
  logic [W-1:0]  sWv, sData;

  mult_mem_engine #(.WIDTH(W), .IN_WIDTH(IW), .ADDR_W(AW), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .EN_mult(EN_mult), .mode(mode),
    .batch_len(batch_len), .mult_valid(mult_valid),
    .mult_input0(mult_input0), .mult_input1(mult_input1),
    .RDY_mult(RDY_mult), .EN_writeMem(EN_writeMem),
    .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
    .DONE_mult(DONE_mult), .EN_blockRead(EN_blockRead),
    .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
    .readMem_val(readMem_val), .VALID_memVal(VALID_memVal),
    .memVal_data(memVal_data), .memVal_ready(memVal_ready),
    .DONE_read(DONE_read), .busy(busy)
  );

  mult_mem_engine #(.WIDTH(W), .IN_WIDTH(IW), .ADDR_W(AW), .SIGNED(1)) dutS (
    .clk(clk), .rst(rst), .EN_mult(EN_mult), .mode(mode),
    .batch_len(batch_len), .mult_valid(mult_valid),
    .mult_input0(mult_input0), .mult_input1(mult_input1),
    .RDY_mult(sRdy), .EN_writeMem(sWe),
    .writeMem_addr(sWa), .writeMem_val(sWv),
    .DONE_mult(sDone), .EN_blockRead(EN_blockRead),
    .EN_readMem(sRe), .readMem_addr(sRa),
    .readMem_val(readMem_val), .VALID_memVal(sValid),
    .memVal_data(sData), .memVal_ready(memVal_ready),
    .DONE_read(sDoneRd), .busy(sBusy)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] mem [DEPTH];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h1000 + i;
    end else if (EN_writeMem) begin
      mem[writeMem_addr] <= writeMem_val;
    end
    if (EN_readMem) readMem_val <= mem[readMem_addr];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  v;
    logic          d;
    int            c;
  } wr_t;

  wr_t          wlog[$];
  logic [W-1:0] sVals[$];
  logic [W-1:0] rdata[$];
  logic         rdone[$];
  int           rcyc[$];
  bit           rdoneSeen = 0;
  bit           prevDone = 0;
  logic         postDoneBusy = 1'b1;
  int           outst = 0;

  always @(negedge clk) begin
    wr_t w;
    int  xfer;
    if (prevDone) postDoneBusy = busy;
    prevDone = DONE_mult;
    if (EN_writeMem) begin
      w.a = writeMem_addr;
      w.v = writeMem_val;
      w.d = DONE_mult;
      w.c = cyc;
      wlog.push_back(w);
    end
    if (sWe) sVals.push_back(sWv);
    xfer = (VALID_memVal && memVal_ready) ? 1 : 0;
    if (EN_readMem) chk("rd_pending", (outst - xfer) < 2, 1);
    if (xfer == 1) begin
      rdata.push_back(memVal_data);
      rdone.push_back(DONE_read);
      rcyc.push_back(cyc);
      if (DONE_read) rdoneSeen = 1;
    end
    if (!rst) outst = 0;
    else outst = outst + (EN_readMem ? 1 : 0) - xfer;
  end

  int lastAcc = 0;
  int readStart = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    wlog.delete();
    sVals.delete();
  endtask

  task automatic startBatch(logic m, logic [AW:0] len);
    clearLogs();
    mode = m;
    batch_len = len;
    EN_mult = 1'b1;
    tick();
    EN_mult = 1'b0;
  endtask

  task automatic sendPair(logic [IW-1:0] a, logic [IW-1:0] b, int gap);
    int   n;
    logic r;
    n = 0;
    mult_valid = 1'b1;
    mult_input0 = a;
    mult_input1 = b;
    do begin
      @(negedge clk);
      r = RDY_mult;
      tick();
      n++;
    end while (!r && n < 50);
    if (!r) chk("rdy_timeout", 0, 1);
    lastAcc = cyc;
    mult_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic waitWrites(int n);
    int k;
    k = 0;
    while (wlog.size() < n && k < 300) begin
      tick();
      k++;
    end
    repeat (2) tick();
    chk("wr_count", wlog.size(), n);
  endtask

  task automatic doRead(bit rnd, int n);
    int k;
    k = 0;
    rdata.delete();
    rdone.delete();
    rcyc.delete();
    rdoneSeen = 0;
    memVal_ready = 1'b1;
    EN_blockRead = 1'b1;
    tick();
    readStart = cyc;
    EN_blockRead = 1'b0;
    while (!rdoneSeen && k < 2000) begin
      memVal_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    memVal_ready = 1'b0;
    repeat (3) tick();
    chk("rd_count", rdata.size(), n);
    chk("rd_idle", busy, 0);
  endtask

  function automatic logic anyOut();
    return |{RDY_mult, EN_writeMem, writeMem_addr, writeMem_val,
             DONE_mult, EN_readMem, readMem_addr, VALID_memVal,
             memVal_data, DONE_read, busy};
  endfunction

  initial begin
    EN_mult = 0; mode = 0; batch_len = '0; mult_valid = 0;
    mult_input0 = '0; mult_input1 = '0;
    EN_blockRead = 0; memVal_ready = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_outs", anyOut(), 0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_outs", anyOut(), 0);

    // last_len starts at DEPTH: read the preloaded pattern
    doRead(0, DEPTH);
    for (int i = 0; i < DEPTH && i < rdata.size(); i++)
      chk("rst_read", rdata[i], 32'h1000 + i);

    // squares, full-depth batch
    startBatch(0, '0);
    for (int i = 0; i < DEPTH; i++) sendPair(IW'(i), IW'(i), 0);
    waitWrites(DEPTH);
    for (int i = 0; i < DEPTH && i < wlog.size(); i++) begin
      chk("sq_addr", wlog[i].a, i);
      chk("sq_val", wlog[i].v, i * i);
      chk("sq_done", wlog[i].d, i == DEPTH - 1);
    end
    chk("sq_idle_after_done", postDoneBusy, 0);
    doRead(0, DEPTH);
    for (int i = 0; i < DEPTH && i < rdata.size(); i++) begin
      chk("sq_read", rdata[i], i * i);
      chk("sq_rdone", rdone[i], i == DEPTH - 1);
    end
    if (rcyc.size() == DEPTH) begin
      chk("rd_latency", rcyc[0] - readStart, 2);
      chk("rd_rate", rcyc[DEPTH-1] - rcyc[0], DEPTH - 1);
    end

    // MAC batch of 4; EN_mult beats EN_blockRead
    clearLogs();
    mode = 1'b1;
    batch_len = 7'd4;
    EN_mult = 1'b1;
    EN_blockRead = 1'b1;
    tick();
    EN_mult = 1'b0;
    EN_blockRead = 1'b0;
    chk("prio_mult", RDY_mult, 1);
    sendPair(16'd1, 16'd2, 0);
    sendPair(16'd3, 16'd4, 0);
    sendPair(16'd5, 16'd6, 0);
    sendPair(16'd7, 16'd8, 0);
    waitWrites(4);
    if (wlog.size() == 4) begin
      chk("mac_v0", wlog[0].v, 2);
      chk("mac_v1", wlog[1].v, 14);
      chk("mac_v2", wlog[2].v, 44);
      chk("mac_v3", wlog[3].v, 100);
      chk("mac_a3", wlog[3].a, 3);
    end
    doRead(0, 4);
    if (rdata.size() == 4) begin
      chk("mac_r0", rdata[0], 2);
      chk("mac_r3", rdata[3], 100);
      chk("mac_rdone", rdone[3], 1);
    end

    // unsigned vs signed products
    startBatch(0, 7'd2);
    sendPair(16'hFFFF, 16'hFFFF, 0);
    sendPair(16'hFFFF, 16'h0002, 0);
    waitWrites(2);
    if (wlog.size() == 2) begin
      chk("u_ffff_sq", wlog[0].v, 32'hFFFE0001);
      chk("u_ffff_x2", wlog[1].v, 32'h0001FFFE);
    end
    if (sVals.size() == 2) begin
      chk("s_m1_sq", sVals[0], 32'h00000001);
      chk("s_m1_x2", sVals[1], 32'hFFFFFFFE);
    end else chk("s_count", sVals.size(), 2);

    // accumulator wraps modulo 2^32
    startBatch(1, 7'd2);
    sendPair(16'hFFFF, 16'hFFFF, 0);
    sendPair(16'hFFFF, 16'hFFFF, 0);
    waitWrites(2);
    if (wlog.size() == 2) chk("mac_wrap", wlog[1].v, 32'hFFFC0002);

    // random back-pressure read
    startBatch(0, 7'd16);
    for (int i = 0; i < 16; i++) sendPair(IW'(3 * i), IW'(i + 7), 0);
    waitWrites(16);
    doRead(1, 16);
    for (int i = 0; i < 16 && i < rdata.size(); i++) begin
      chk("bp_read", rdata[i], 3 * i * (i + 7));
      chk("bp_rdone", rdone[i], i == 15);
    end

    // mult_valid low on alternate cycles
    startBatch(0, 7'd8);
    for (int i = 0; i < 8; i++) sendPair(IW'(i + 1), 16'd10, 1);
    waitWrites(8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk("gap_addr", wlog[i].a, i);
      chk("gap_val", wlog[i].v, 10 * (i + 1));
      chk("gap_done", wlog[i].d, i == 7);
    end
    if (wlog.size() == 8) chk("gap_done_cyc", wlog[7].c, lastAcc);
    chk("gap_idle_after_done", postDoneBusy, 0);

    // reset mid-batch
    startBatch(0, '0);
    for (int i = 0; i < 10; i++) sendPair(IW'(i + 2), 16'd3, 0);
    tick();
    chk("abort_pre_writes", wlog.size(), 10);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rst_outs", anyOut(), 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle_outs", anyOut(), 0);
    clearLogs();
    repeat (5) tick();
    chk("abort_no_writes", wlog.size(), 0);
    startBatch(0, 7'd2);
    sendPair(16'd2, 16'd3, 0);
    sendPair(16'd4, 16'd5, 0);
    waitWrites(2);
    if (wlog.size() == 2) begin
      chk("restart_a0", wlog[0].a, 0);
      chk("restart_v0", wlog[0].v, 6);
      chk("restart_a1", wlog[1].a, 1);
      chk("restart_v1", wlog[1].v, 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_mem_engine.md
MULT_MEM_ENGINE -- requirements
Module: mult_mem_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: product, accumulator and memory word width.
REQ-002 The block SHALL have parameter IN_WIDTH, default 16: operand width.
REQ-003 The block SHALL have parameter ADDR_W, default 6: memory address width; DEPTH = 2^ADDR_W.
REQ-004 The block SHALL have parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands with sign-extended product.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 The block SHALL have the following ports:
- clk  in  1  clock, all logic on its rising edge
- rst  in  1  synchronous active-low reset
- EN_mult  in  1  start-batch request
- mode  in  1  0 = multiply, 1 = multiply-accumulate; sampled at batch start
- batch_len  in  ADDR_W+1  entries per batch; 0 is treated as DEPTH; sampled at batch start
- mult_valid  in  1  operand pair valid
- mult_input0, mult_input1  in  IN_WIDTH  operands
- RDY_mult  out  1  operand pair accepted when mult_valid && RDY_mult
- EN_writeMem  out  1  memory write enable
- writeMem_addr  out  ADDR_W  write address
- writeMem_val  out  WIDTH  write data
- DONE_mult  out  1  one-cycle pulse on the final write
- EN_blockRead  in  1  start block-read request
- EN_readMem  out  1  memory read enable
- readMem_addr  out  ADDR_W  read address
- readMem_val  in  WIDTH  read data, valid exactly one cycle after EN_readMem
- VALID_memVal  out  1  output word valid
- memVal_data  out  WIDTH  output word
- memVal_ready  in  1  consumer ready; a word transfers when VALID_memVal && memVal_ready
- DONE_read  out  1  one-cycle pulse with the last transferred word
- busy  out  1  high whenever state != IDLE

Function
REQ-007 The state machine SHALL have the states IDLE, MULT and READ.
REQ-008 In IDLE, EN_mult SHALL cause a transition to MULT, latch mode and the effective length, and clear the write counter and the accumulator.
REQ-009 In IDLE, EN_blockRead with EN_mult low SHALL cause a transition to READ; when both are high, EN_mult SHALL win.
REQ-010 RDY_mult SHALL be high only in MULT while accepted pairs < latched length, and SHALL be low in all other states.
REQ-011 The product SHALL be the full 2*IN_WIDTH product, zero- or sign-extended to WIDTH per SIGNED, or truncated to its low WIDTH bits when 2*IN_WIDTH > WIDTH.
REQ-012 In mode 0, writeMem_val SHALL equal the product.
REQ-013 In mode 1, writeMem_val SHALL equal the running sum of products in the batch, modulo 2^WIDTH.
REQ-014 A pair accepted in cycle k SHALL produce EN_writeMem=1 in cycle k+1, with writeMem_addr equal to the count of prior writes in the batch (0, 1, 2, ...).
REQ-015 Gaps in mult_valid SHALL stall the write sequence without skipping any address.
REQ-016 DONE_mult SHALL pulse in the same cycle as the final EN_writeMem, and the FSM SHALL be in IDLE in the next cycle.
REQ-017 At each DONE_mult the block SHALL record the batch length as last_len.
REQ-018 last_len SHALL be DEPTH after reset.
REQ-019 READ SHALL issue EN_readMem for addresses 0 .. last_len-1 in order.
REQ-020 Each returned readMem_val SHALL enter a 2-entry output FIFO.
REQ-021 A read SHALL be issued only when (FIFO occupancy + reads in flight) < 2, so that no word is ever dropped under back-pressure.
REQ-022 VALID_memVal SHALL equal FIFO not-empty, and memVal_data SHALL be the FIFO head.
REQ-023 With memVal_ready held high, the block SHALL sustain one word per cycle, with the first VALID_memVal asserted 2 cycles after entering READ.
REQ-024 DONE_read SHALL pulse with the transfer of word last_len-1, after which the FSM SHALL return to IDLE.
REQ-025 EN_mult SHALL be ignored in READ, and EN_blockRead SHALL be ignored in MULT.
REQ-026 Write and read counters SHALL never wrap within a batch; a batch length of DEPTH SHALL end at address DEPTH-1.

Reset
REQ-027 While rst=0 at a rising edge, the block SHALL enter IDLE, clear the counters, accumulator and FIFO, and set last_len to DEPTH.
REQ-028 While rst=0, every output SHALL be 0: RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, DONE_mult, EN_readMem, readMem_addr, VALID_memVal, memVal_data, DONE_read and busy.
REQ-029 Reset asserted mid-batch or mid-read SHALL abort the operation with no further writes, reads or outputs.

Verification
REQ-030 The bench SHALL cover: mode 0, batch_len=0, operands i,i for i=0..63 -> writes addr i = i*i, DONE_mult on addr 63; block read then returns 0,1,4,...,3969 and DONE_read with 3969.
REQ-031 The bench SHALL cover: mode 1, batch_len=4, pairs (1,2),(3,4),(5,6),(7,8) -> writes 2,14,44,100 to addresses 0-3; block read returns exactly 4 words.
REQ-032 The bench SHALL cover: SIGNED=0, 0xFFFF*0xFFFF -> 0xFFFE0001; SIGNED=1, 0xFFFF*0x0002 -> 0xFFFFFFFE; mode 1 sums wrap modulo 2^32.
REQ-033 The bench SHALL cover: a read with memVal_ready toggling randomly -> all words delivered in order, none duplicated or lost, and EN_readMem never issued with 2 words pending.
REQ-034 The bench SHALL cover: mult_valid low on alternate cycles -> contiguous addresses and the correct DONE_mult cycle.
REQ-035 The bench SHALL cover: rst=0 after 10 writes of a 64-entry batch -> all outputs 0 the next cycle, IDLE; a new batch restarts at address 0.
